// File: rtl/dma_pkg.sv
// Shared DMA types: the descriptor handed to the engine and the
// multi-channel scheduler state encoding.
package dma_pkg;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [15:0] len;
    } s_dma_desc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RETIRE = 2'd3
    } dma_mc_state_e;

    localparam int DMA_MC_MAX_CH = 16;

endpackage

// File: rtl/dma_desc_queue.sv
// Flop-based descriptor FIFO for one channel. Pointers carry an extra wrap
// bit so full and empty are told apart without a separate counter.
module dma_desc_queue
    import dma_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  s_dma_desc_t desc_i,
    output s_dma_desc_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(QDEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    s_dma_desc_t mem_q [QDEPTH];
    s_dma_desc_t mem_d [QDEPTH];

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // Flush takes precedence over any same-cycle push or pop.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i && !full_o) begin
                mem_d[wr_q[AW-1:0]] = desc_i;
                wr_d = wr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_d = rd_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/dma_mc_scheduler.sv
// Multi-channel descriptor front-end: per-channel queues, RR or fixed-priority
// arbitration, and a single-outstanding launch/retire FSM toward one engine.
module dma_mc_scheduler
    import dma_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int QDEPTH      = 2,
    parameter int PRIO_MODE   = 0,
    parameter int HALT_ON_ERR = 1,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic        [NUM_CH-1:0] ch_go_i,
    input  s_dma_desc_t [NUM_CH-1:0] ch_desc_i,
    input  logic        [NUM_CH-1:0] ch_abort_i,
    output logic        [NUM_CH-1:0] ch_ready_o,
    output logic        [NUM_CH-1:0] ch_busy_o,
    output logic        [NUM_CH-1:0] ch_done_o,
    output logic        [NUM_CH-1:0] ch_err_o,
    output logic        [NUM_CH-1:0] ch_halted_o,
    output logic        [NUM_CH-1:0] ch_drop_o,
    output logic                     eng_go_o,
    output s_dma_desc_t              eng_desc_o,
    output logic        [CH_W-1:0]   eng_ch_o,
    input  logic                     eng_done_i,
    input  logic                     eng_err_i,
    output dma_mc_state_e            dbg_state_o
);

    // Handshake: a push on channel c is taken in any cycle where ch_go_i[c]
    // and ch_ready_o[c] are both high; ch_ready_o never depends on ch_go_i.

    function automatic logic [CH_W-1:0] ch_wrap_add(input logic [CH_W-1:0] base,
                                                    input int unsigned     off);
        logic [CH_W:0] s;
        s = {1'b0, base} + (CH_W+1)'(off);
        if (s >= (CH_W+1)'(NUM_CH)) s = s - (CH_W+1)'(NUM_CH);
        return s[CH_W-1:0];
    endfunction

    dma_mc_state_e state_q, state_d;
    logic [CH_W-1:0] eng_ch_q, eng_ch_d;
    s_dma_desc_t     eng_desc_q, eng_desc_d;
    logic            err_q, err_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            kill_q, kill_d;
    logic [NUM_CH-1:0] halted_q, halted_d;
    logic [NUM_CH-1:0] drop_q, drop_d;

    logic [NUM_CH-1:0] q_full, q_empty, q_push, q_pop, q_flush, eligible;
    s_dma_desc_t       q_head [NUM_CH];
    logic              win_found;
    logic [CH_W-1:0]   win_ch;
    logic [CH_W-1:0]   cand;
    logic              pop_en;
    logic              err_halt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dma_desc_queue #(.QDEPTH(QDEPTH)) u_queue (
            .clk     (clk),
            .rstn    (rstn),
            .flush_i (q_flush[c]),
            .push_i  (q_push[c]),
            .pop_i   (q_pop[c]),
            .desc_i  (ch_desc_i[c]),
            .head_o  (q_head[c]),
            .full_o  (q_full[c]),
            .empty_o (q_empty[c])
        );
    end

    assign eligible = ~q_empty & ~halted_q;

    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (PRIO_MODE == 1) ? ch_wrap_add('0, i) : ch_wrap_add(rr_ptr_q, i);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_ch    = cand;
            end
        end
    end

    // kill_q marks the in-flight descriptor as already flushed by an abort,
    // so the retire pop must not consume a descriptor pushed afterwards.
    always_comb begin
        state_d    = state_q;
        eng_ch_d   = eng_ch_q;
        eng_desc_d = eng_desc_q;
        err_d      = err_q;
        rr_ptr_d   = rr_ptr_q;
        kill_d     = kill_q | ch_abort_i[eng_ch_q];
        pop_en     = 1'b0;
        err_halt   = 1'b0;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (win_found) begin
                    eng_ch_d   = win_ch;
                    eng_desc_d = q_head[win_ch];
                    err_d      = 1'b0;
                    kill_d     = ch_abort_i[win_ch];
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (eng_done_i) begin
                    err_d   = eng_err_i;
                    state_d = RETIRE;
                end
            end
            RETIRE: begin
                pop_en   = 1'b1;
                err_halt = err_q && (HALT_ON_ERR != 0);
                rr_ptr_d = ch_wrap_add(eng_ch_q, 1);
                kill_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        halted_d    = halted_q;
        drop_d      = drop_q;
        q_push      = '0;
        q_pop       = '0;
        q_flush     = '0;
        ch_ready_o  = ~q_full & ~halted_q;
        ch_busy_o   = '0;
        ch_done_o   = '0;
        ch_err_o    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            q_flush[c]   = ch_abort_i[c] | (err_halt && (eng_ch_q == CH_W'(c)));
            q_push[c]    = ch_go_i[c] & ch_ready_o[c] & ~ch_abort_i[c];
            q_pop[c]     = pop_en && (eng_ch_q == CH_W'(c)) && !kill_q;
            ch_busy_o[c] = ~q_empty[c] | ((state_q != IDLE) && (eng_ch_q == CH_W'(c)));
            ch_done_o[c] = (state_q == RETIRE) && (eng_ch_q == CH_W'(c));
            ch_err_o[c]  = ch_done_o[c] & err_q;
            if (ch_abort_i[c]) begin
                halted_d[c] = 1'b0;
                drop_d[c]   = 1'b0;
            end else begin
                if (err_halt && (eng_ch_q == CH_W'(c))) halted_d[c] = 1'b1;
                if (ch_go_i[c] && !ch_ready_o[c])       drop_d[c]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            eng_ch_q   <= '0;
            eng_desc_q <= '0;
            err_q      <= 1'b0;
            rr_ptr_q   <= '0;
            kill_q     <= 1'b0;
            halted_q   <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            eng_ch_q   <= eng_ch_d;
            eng_desc_q <= eng_desc_d;
            err_q      <= err_d;
            rr_ptr_q   <= rr_ptr_d;
            kill_q     <= kill_d;
            halted_q   <= halted_d;
            drop_q     <= drop_d;
        end
    end

    assign eng_go_o    = (state_q == LAUNCH);
    assign eng_desc_o  = eng_desc_q;
    assign eng_ch_o    = eng_ch_q;
    assign ch_halted_o = halted_q;
    assign ch_drop_o   = drop_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dma_mc_scheduler.sv
// Directed bench for dma_mc_scheduler: an RR instance and a fixed-priority
// instance share stimulus; a hand-driven engine answers launches.
module tb_dma_mc_scheduler;
    import dma_pkg::*;

    logic              clk;
    logic              rstn;
    logic        [3:0] ch_go_i;
    s_dma_desc_t [3:0] ch_desc_i;
    logic        [3:0] ch_abort_i;
    logic              eng_done_i;
    logic              eng_err_i;

    logic [3:0] ch_ready_o, ch_busy_o, ch_done_o, ch_err_o, ch_halted_o, ch_drop_o;
    logic        eng_go_o;
    s_dma_desc_t eng_desc_o;
    logic [1:0]  eng_ch_o;
    dma_mc_state_e dbg_state_o;

    logic [3:0] fp_ready, fp_busy, fp_done, fp_err, fp_halted, fp_drop;
    logic        fp_go;
    s_dma_desc_t fp_desc;
    logic [1:0]  fp_ch;
    dma_mc_state_e fp_state;

    int n_assert = 0;
    int n_fail   = 0;

    dma_mc_scheduler #(.NUM_CH(4), .QDEPTH(2), .PRIO_MODE(0), .HALT_ON_ERR(1)) u_dut (
        .clk(clk), .rstn(rstn), .ch_go_i(ch_go_i), .ch_desc_i(ch_desc_i), .ch_abort_i(ch_abort_i),
        .ch_ready_o(ch_ready_o), .ch_busy_o(ch_busy_o), .ch_done_o(ch_done_o), .ch_err_o(ch_err_o),
        .ch_halted_o(ch_halted_o), .ch_drop_o(ch_drop_o), .eng_go_o(eng_go_o), .eng_desc_o(eng_desc_o),
        .eng_ch_o(eng_ch_o), .eng_done_i(eng_done_i), .eng_err_i(eng_err_i), .dbg_state_o(dbg_state_o)
    );

    dma_mc_scheduler #(.NUM_CH(4), .QDEPTH(2), .PRIO_MODE(1), .HALT_ON_ERR(1)) u_dut_fp (
        .clk(clk), .rstn(rstn), .ch_go_i(ch_go_i), .ch_desc_i(ch_desc_i), .ch_abort_i(ch_abort_i),
        .ch_ready_o(fp_ready), .ch_busy_o(fp_busy), .ch_done_o(fp_done), .ch_err_o(fp_err),
        .ch_halted_o(fp_halted), .ch_drop_o(fp_drop), .eng_go_o(fp_go), .eng_desc_o(fp_desc),
        .eng_ch_o(fp_ch), .eng_done_i(eng_done_i), .eng_err_i(eng_err_i), .dbg_state_o(fp_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic s_dma_desc_t mk_desc(input int c, input int j);
        s_dma_desc_t d;
        d.src_addr = 32'hA000_0000 + 32'(c * 16 + j);
        d.dst_addr = 32'hB000_0000 + 32'(c * 16 + j);
        d.len      = 16'(c * 2 + j + 1);
        return d;
    endfunction

    task automatic do_reset();
        rstn       = 1'b0;
        ch_go_i    = '0;
        ch_abort_i = '0;
        eng_done_i = 1'b0;
        eng_err_i  = 1'b0;
        for (int c = 0; c < 4; c++) ch_desc_i[c] = '0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    // Steps until the RR instance launches; expiry is a failed comparison.
    task automatic wait_launch(output int n);
        n = 0;
        while (!eng_go_o && n < 20) begin
            step();
            n++;
        end
        chk("launch_seen", 32'(eng_go_o), 32'd1);
    endtask

    // Called in WAIT: one-cycle done pulse, returns in the RETIRE cycle.
    task automatic serve(input logic err);
        eng_done_i = 1'b1;
        eng_err_i  = err;
        step();
        eng_done_i = 1'b0;
        eng_err_i  = 1'b0;
    endtask

    task automatic expect_no_launch(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            step();
            if (eng_go_o) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int n;
        do_reset();

        // reset state
        chk("rst_ready", 32'(ch_ready_o), 32'hF);
        chk("rst_busy", 32'(ch_busy_o), 32'h0);
        chk("rst_done", 32'(ch_done_o | ch_err_o), 32'h0);
        chk("rst_flags", 32'(ch_halted_o | ch_drop_o), 32'h0);
        chk("rst_go", 32'(eng_go_o), 32'd0);
        chk("rst_ch", 32'(eng_ch_o), 32'd0);
        chk("rst_state", 32'(dbg_state_o), 32'(IDLE));

        // 1: single push on ch2, latency T+2 / D+1
        ch_go_i      = 4'b0100;
        ch_desc_i[2] = mk_desc(2, 0);
        step();
        ch_go_i = '0;
        chk("t1_go_early", 32'(eng_go_o), 32'd0);
        chk("t1_busy", 32'(ch_busy_o), 32'h4);
        step();
        chk("t1_go", 32'(eng_go_o), 32'd1);
        chk("t1_ch", 32'(eng_ch_o), 32'd2);
        chk("t1_desc", eng_desc_o.src_addr, 32'hA000_0020);
        step();
        chk("t1_go_pulse", 32'(eng_go_o), 32'd0);
        eng_err_i = 1'b1;
        step();
        eng_err_i = 1'b0;
        chk("t1_err_alone", 32'(dbg_state_o), 32'(WAIT));
        serve(1'b0);
        chk("t1_done", 32'(ch_done_o), 32'h4);
        chk("t1_noerr", 32'(ch_err_o), 32'h0);
        step();
        chk("t1_done_pulse", 32'(ch_done_o), 32'h0);
        chk("t1_idle_busy", 32'(ch_busy_o), 32'h0);

        // 2: RR vs fixed priority, two descriptors per channel
        do_reset();
        for (int j = 0; j < 2; j++) begin
            ch_go_i = 4'hF;
            for (int c = 0; c < 4; c++) ch_desc_i[c] = mk_desc(c, j);
            step();
        end
        ch_go_i = '0;
        for (int i = 0; i < 8; i++) begin
            wait_launch(n);
            if (i > 0) chk("t2_gap", 32'(n), 32'd2);
            chk("t2_rr_ch", 32'(eng_ch_o), 32'(i % 4));
            chk("t2_rr_desc", eng_desc_o.src_addr, 32'hA000_0000 + 32'((i % 4) * 16 + i / 4));
            chk("t2_fp_go", 32'(fp_go), 32'd1);
            chk("t2_fp_ch", 32'(fp_ch), 32'(i / 2));
            chk("t2_fp_desc", fp_desc.src_addr, 32'hA000_0000 + 32'((i / 2) * 16 + i % 2));
            step();
            serve(1'b0);
        end
        step();
        chk("t2_drained", 32'(ch_busy_o | fp_busy), 32'h0);

        // 3: overfill ch1, drop flag, abort clears it
        do_reset();
        ch_go_i      = 4'b0010;
        ch_desc_i[1] = mk_desc(1, 0);
        step();
        ch_desc_i[1] = mk_desc(1, 1);
        step();
        chk("t3_full_ready", 32'(ch_ready_o), 32'hD);
        ch_desc_i[1] = mk_desc(1, 2);
        step();
        ch_go_i = '0;
        chk("t3_drop", 32'(ch_drop_o), 32'h2);
        chk("t3_ready", 32'(ch_ready_o), 32'hD);
        ch_abort_i = 4'b0010;
        step();
        ch_abort_i = '0;
        chk("t3_drop_clr", 32'(ch_drop_o), 32'h0);
        chk("t3_ready_back", 32'(ch_ready_o), 32'hF);
        chk("t3_busy_inflight", 32'(ch_busy_o), 32'h2);
        serve(1'b0);
        chk("t3_done", 32'(ch_done_o), 32'h2);
        expect_no_launch("t3_no_relaunch", 4);
        chk("t3_busy_end", 32'(ch_busy_o), 32'h0);

        // 4: error on ch3 halts and flushes it
        do_reset();
        ch_go_i      = 4'b1000;
        ch_desc_i[3] = mk_desc(3, 0);
        step();
        ch_desc_i[3] = mk_desc(3, 1);
        step();
        ch_go_i = '0;
        wait_launch(n);
        chk("t4_ch", 32'(eng_ch_o), 32'd3);
        step();
        serve(1'b1);
        chk("t4_done", 32'(ch_done_o), 32'h8);
        chk("t4_err", 32'(ch_err_o), 32'h8);
        step();
        chk("t4_halted", 32'(ch_halted_o), 32'h8);
        chk("t4_ready", 32'(ch_ready_o), 32'h7);
        chk("t4_flushed", 32'(ch_busy_o), 32'h0);
        ch_go_i = 4'b1000;
        step();
        ch_go_i = '0;
        chk("t4_drop_halted", 32'(ch_drop_o), 32'h8);
        expect_no_launch("t4_no_relaunch", 5);
        ch_abort_i = 4'b1000;
        step();
        ch_abort_i = '0;
        chk("t4_unhalt", 32'(ch_halted_o | ch_drop_o), 32'h0);
        ch_go_i      = 4'b1000;
        ch_desc_i[3] = mk_desc(3, 7);
        step();
        ch_go_i = '0;
        wait_launch(n);
        chk("t4_relaunch_desc", eng_desc_o.src_addr, 32'hA000_0037);

        // 5a: abort ch0 in flight with one queued behind it
        do_reset();
        ch_go_i      = 4'b0001;
        ch_desc_i[0] = mk_desc(0, 0);
        step();
        ch_desc_i[0] = mk_desc(0, 1);
        step();
        ch_go_i = '0;
        wait_launch(n);
        step();
        ch_abort_i = 4'b0001;
        step();
        ch_abort_i = '0;
        chk("t5_busy", 32'(ch_busy_o), 32'h1);
        serve(1'b0);
        chk("t5_done", 32'(ch_done_o), 32'h1);
        expect_no_launch("t5_no_launch", 5);
        chk("t5_idle", 32'(ch_busy_o), 32'h0);

        // 5b: push after abort survives the retire of the aborted one
        do_reset();
        ch_go_i      = 4'b0001;
        ch_desc_i[0] = mk_desc(0, 0);
        step();
        ch_go_i = '0;
        wait_launch(n);
        step();
        ch_abort_i = 4'b0001;
        step();
        ch_abort_i   = '0;
        ch_go_i      = 4'b0001;
        ch_desc_i[0] = mk_desc(0, 5);
        step();
        ch_go_i = '0;
        serve(1'b0);
        chk("t5b_done", 32'(ch_done_o), 32'h1);
        wait_launch(n);
        chk("t5b_desc", eng_desc_o.src_addr, 32'hA000_0005);

        // 6: async reset during WAIT, stale done afterwards
        do_reset();
        ch_go_i      = 4'b0010;
        ch_desc_i[1] = mk_desc(1, 3);
        step();
        ch_go_i = '0;
        wait_launch(n);
        step();
        chk("t6_in_wait", 32'(dbg_state_o), 32'(WAIT));
        #3;
        rstn = 1'b0;
        #1;
        chk("t6_ready", 32'(ch_ready_o), 32'hF);
        chk("t6_busy", 32'(ch_busy_o), 32'h0);
        chk("t6_ch", 32'(eng_ch_o), 32'd0);
        chk("t6_desc", eng_desc_o.src_addr, 32'd0);
        chk("t6_state", 32'(dbg_state_o), 32'(IDLE));
        step();
        rstn       = 1'b1;
        eng_done_i = 1'b1;
        eng_err_i  = 1'b1;
        step();
        eng_done_i = 1'b0;
        eng_err_i  = 1'b0;
        chk("t6_stale_done", 32'(ch_done_o | ch_err_o), 32'h0);
        chk("t6_stale_state", 32'(dbg_state_o), 32'(IDLE));
        expect_no_launch("t6_no_launch", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
